// File: rtl/controle_nivel_agua.sv
// Water-level control FSM: debounced zone classification of strobed BCD level samples,
// fill-valve/alarm control, manual override and fill-timeout fault.
module controle_nivel_agua #(
    parameter int N_CONFIRMA = 3,
    parameter int TIMEOUT    = 50_000_000,
    parameter int W_TIMEOUT  = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] nivel,
    input  logic        nivel_pronto,
    input  logic [11:0] nv_crit,
    input  logic [11:0] nv_alto,
    input  logic [11:0] nv_baixo,
    input  logic        manual,
    input  logic        abrir_valv,
    input  logic        limpa_falha,
    output logic        valvula,
    output logic        alarme,
    output logic        falha,
    output logic [2:0]  db_estado
);

    localparam int W_CNT = (N_CONFIRMA < 2) ? 1 : $clog2(N_CONFIRMA + 1);

    typedef enum logic [2:0] {
        INICIAL  = 3'd0,
        OCIOSO   = 3'd1,
        ENCHENDO = 3'd2,
        CRITICO  = 3'd3,
        FALHA    = 3'd4,
        MANUAL   = 3'd5
    } estado_t;

    typedef enum logic [1:0] {
        Z_MEIO  = 2'd0,
        Z_BAIXO = 2'd1,
        Z_ALTO  = 2'd2,
        Z_CRIT  = 2'd3
    } zona_t;

    estado_t              estado_q, estado_d;
    zona_t                last_zone_q, last_zone_d;
    zona_t                zona_s;
    logic [W_CNT-1:0]     cnt_q, cnt_d, cnt_inc_s;
    logic [W_TIMEOUT-1:0] tmo_q, tmo_d;
    logic                 confirmado_s;
    logic                 valvula_q, valvula_d;
    logic                 alarme_q, alarme_d;
    logic                 falha_q, falha_d;

    // Zone of the current sample, CRIT first so misordered thresholds stay deterministic
    always_comb begin
        if (nivel >= nv_crit) begin
            zona_s = Z_CRIT;
        end else if (nivel >= nv_alto) begin
            zona_s = Z_ALTO;
        end else if (nivel <= nv_baixo) begin
            zona_s = Z_BAIXO;
        end else begin
            zona_s = Z_MEIO;
        end
    end

    // Saturating run-length of identical zones and the resulting confirmation
    always_comb begin
        if (zona_s != last_zone_q) begin
            cnt_inc_s = W_CNT'(1);
        end else if (cnt_q == W_CNT'(N_CONFIRMA)) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + W_CNT'(1);
        end
        confirmado_s = nivel_pronto && (cnt_inc_s == W_CNT'(N_CONFIRMA));
    end

    // Next state: fault handling, then manual, then confirmed zones, then timeout
    always_comb begin
        estado_d = estado_q;
        if (estado_q == FALHA) begin
            if (limpa_falha) begin
                estado_d = OCIOSO;
            end else begin
                estado_d = FALHA;
            end
        end else if (manual) begin
            estado_d = MANUAL;
        end else begin
            case (estado_q)
                INICIAL: begin
                    if (nivel_pronto) begin
                        estado_d = OCIOSO;
                    end else begin
                        estado_d = INICIAL;
                    end
                end
                MANUAL: estado_d = OCIOSO;
                OCIOSO: begin
                    if (confirmado_s && zona_s == Z_BAIXO) begin
                        estado_d = ENCHENDO;
                    end else if (confirmado_s && zona_s == Z_CRIT) begin
                        estado_d = CRITICO;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end
                ENCHENDO: begin
                    if (confirmado_s && zona_s == Z_CRIT) begin
                        estado_d = CRITICO;
                    end else if (confirmado_s && zona_s == Z_ALTO) begin
                        estado_d = OCIOSO;
                    end else if (tmo_q == W_TIMEOUT'(TIMEOUT - 1)) begin
                        estado_d = FALHA;
                    end else begin
                        estado_d = ENCHENDO;
                    end
                end
                CRITICO: begin
                    if (confirmado_s && (zona_s == Z_MEIO || zona_s == Z_BAIXO)) begin
                        estado_d = OCIOSO;
                    end else begin
                        estado_d = CRITICO;
                    end
                end
                default: estado_d = INICIAL;
            endcase
        end
    end

    // Counters, last zone and output decode from the next state
    always_comb begin
        if (nivel_pronto) begin
            last_zone_d = zona_s;
        end else begin
            last_zone_d = last_zone_q;
        end

        if (estado_d != estado_q) begin
            cnt_d = '0;
        end else if (nivel_pronto) begin
            cnt_d = cnt_inc_s;
        end else begin
            cnt_d = cnt_q;
        end

        if (estado_d == ENCHENDO && estado_q == ENCHENDO) begin
            tmo_d = tmo_q + W_TIMEOUT'(1);
        end else begin
            tmo_d = '0;
        end

        // In manual the valve is cut on a single CRIT sample, without debounce
        case (estado_d)
            ENCHENDO: begin
                valvula_d = 1'b1;
                alarme_d  = 1'b0;
            end
            MANUAL: begin
                valvula_d = abrir_valv && (last_zone_d != Z_CRIT);
                alarme_d  = (last_zone_d == Z_CRIT);
            end
            CRITICO, FALHA: begin
                valvula_d = 1'b0;
                alarme_d  = 1'b1;
            end
            default: begin
                valvula_d = 1'b0;
                alarme_d  = 1'b0;
            end
        endcase
        falha_d = (estado_d == FALHA);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q    <= INICIAL;
            last_zone_q <= Z_MEIO;
            cnt_q       <= '0;
            tmo_q       <= '0;
            valvula_q   <= 1'b0;
            alarme_q    <= 1'b0;
            falha_q     <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            last_zone_q <= last_zone_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            valvula_q   <= valvula_d;
            alarme_q    <= alarme_d;
            falha_q     <= falha_d;
        end
    end

    assign valvula   = valvula_q;
    assign alarme    = alarme_q;
    assign falha     = falha_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_nivel_agua.sv
// Directed bench for controle_nivel_agua with TIMEOUT reduced to 20 cycles.
module tb_controle_nivel_agua;

    logic        clock_s = 1'b0;
    logic        reset_s;
    logic [11:0] nivel_s;
    logic        nivel_pronto_s;
    logic [11:0] nv_crit_s, nv_alto_s, nv_baixo_s;
    logic        manual_s, abrir_valv_s, limpa_falha_s;
    logic        valvula_s, alarme_s, falha_s;
    logic [2:0]  db_estado_s;

    int n_checks = 0;
    int n_fails  = 0;

    controle_nivel_agua #(
        .N_CONFIRMA(3),
        .TIMEOUT   (20),
        .W_TIMEOUT (26)
    ) dut (
        .clock       (clock_s),
        .reset       (reset_s),
        .nivel       (nivel_s),
        .nivel_pronto(nivel_pronto_s),
        .nv_crit     (nv_crit_s),
        .nv_alto     (nv_alto_s),
        .nv_baixo    (nv_baixo_s),
        .manual      (manual_s),
        .abrir_valv  (abrir_valv_s),
        .limpa_falha (limpa_falha_s),
        .valvula     (valvula_s),
        .alarme      (alarme_s),
        .falha       (falha_s),
        .db_estado   (db_estado_s)
    );

    always #5 clock_s = ~clock_s;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clock_s);
        #1;
    endtask

    task automatic strobe(input logic [11:0] v);
        nivel_s        = v;
        nivel_pronto_s = 1'b1;
        tick();
        nivel_pronto_s = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic v, input logic a, input logic f);
        check_value({tag, ".estado"}, 32'(db_estado_s), 32'(st));
        check_value({tag, ".valvula"}, 32'(valvula_s), 32'(v));
        check_value({tag, ".alarme"}, 32'(alarme_s), 32'(a));
        check_value({tag, ".falha"}, 32'(falha_s), 32'(f));
    endtask

    initial begin
        reset_s = 1'b0;
        nivel_s = 12'h000;
        nivel_pronto_s = 1'b0;
        nv_crit_s = 12'h027;
        nv_alto_s = 12'h024;
        nv_baixo_s = 12'h012;
        manual_s = 1'b0;
        abrir_valv_s = 1'b0;
        limpa_falha_s = 1'b0;

        tick();
        tick();
        check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        reset_s = 1'b1;
        tick();
        check_outs("inicial_hold", 3'd0, 1'b0, 1'b0, 1'b0);

        strobe(12'h018);
        check_outs("first_strobe", 3'd1, 1'b0, 1'b0, 1'b0);

        // Interrupted BAIXO run must not confirm
        strobe(12'h010);
        strobe(12'h015);
        strobe(12'h010);
        check_outs("no_confirm", 3'd1, 1'b0, 1'b0, 1'b0);
        strobe(12'h010);
        check_outs("baixo_2of3", 3'd1, 1'b0, 1'b0, 1'b0);
        strobe(12'h010);
        check_outs("enchendo", 3'd2, 1'b1, 1'b0, 1'b0);

        strobe(12'h025);
        strobe(12'h025);
        check_outs("alto_2of3", 3'd2, 1'b1, 1'b0, 1'b0);
        strobe(12'h025);
        check_outs("alto_ocioso", 3'd1, 1'b0, 1'b0, 1'b0);

        repeat (3) strobe(12'h010);
        check_outs("enchendo2", 3'd2, 1'b1, 1'b0, 1'b0);
        repeat (3) strobe(12'h030);
        check_outs("critico", 3'd3, 1'b0, 1'b1, 1'b0);
        strobe(12'h020);
        strobe(12'h020);
        check_outs("critico_hold", 3'd3, 1'b0, 1'b1, 1'b0);
        strobe(12'h020);
        check_outs("meio_ocioso", 3'd1, 1'b0, 1'b0, 1'b0);

        // Timeout: FALHA exactly 20 cycles after entering ENCHENDO
        repeat (3) strobe(12'h010);
        repeat (19) tick();
        check_outs("tmo_minus1", 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        check_outs("falha", 3'd4, 1'b0, 1'b1, 1'b1);
        manual_s = 1'b1;
        tick();
        tick();
        check_outs("falha_ign_manual", 3'd4, 1'b0, 1'b1, 1'b1);
        manual_s = 1'b0;
        limpa_falha_s = 1'b1;
        tick();
        limpa_falha_s = 1'b0;
        check_outs("limpa_falha", 3'd1, 1'b0, 1'b0, 1'b0);

        // Manual mode with immediate CRIT safety cut
        manual_s = 1'b1;
        tick();
        check_outs("manual_entry", 3'd5, 1'b0, 1'b0, 1'b0);
        abrir_valv_s = 1'b1;
        tick();
        check_outs("manual_open", 3'd5, 1'b1, 1'b0, 1'b0);
        strobe(12'h030);
        check_outs("safety_cut", 3'd5, 1'b0, 1'b1, 1'b0);
        manual_s = 1'b0;
        abrir_valv_s = 1'b0;
        tick();
        check_outs("manual_exit", 3'd1, 1'b0, 1'b0, 1'b0);

        // Confirmation on the timeout edge wins
        repeat (3) strobe(12'h010);
        check_outs("enchendo3", 3'd2, 1'b1, 1'b0, 1'b0);
        repeat (17) tick();
        repeat (3) strobe(12'h025);
        check_outs("confirm_vs_tmo", 3'd1, 1'b0, 1'b0, 1'b0);

        // Manual on the confirming edge wins
        strobe(12'h010);
        strobe(12'h010);
        manual_s = 1'b1;
        strobe(12'h010);
        check_outs("manual_vs_confirm", 3'd5, 1'b0, 1'b0, 1'b0);
        manual_s = 1'b0;
        tick();
        check_outs("manual_exit2", 3'd1, 1'b0, 1'b0, 1'b0);

        // Reset in ENCHENDO closes the valve on that edge
        repeat (3) strobe(12'h010);
        check_outs("enchendo4", 3'd2, 1'b1, 1'b0, 1'b0);
        reset_s = 1'b0;
        tick();
        check_outs("reset_mid", 3'd0, 1'b0, 1'b0, 1'b0);
        reset_s = 1'b1;
        tick();
        check_outs("after_reset", 3'd0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/controle_nivel_agua.md
# controle_nivel_agua

Water-level control FSM downstream of the serial command receiver: consumes the BCD thresholds `nv_crit`, `nv_alto`, `nv_baixo` and the `manual`/`abrir_valv` flags, plus strobed level samples from the sensor path. It drives the fill valve, the alarm and the fault flag. Level decisions are debounced over N consecutive samples, and a fill timeout detects a stuck or empty supply.

## Interface
- `N_CONFIRMA`, default 3: consecutive same-zone samples required to confirm a zone (≥1).
- `TIMEOUT`, default 50_000_000: clock cycles allowed in ENCHENDO before FALHA.
- `W_TIMEOUT`, default 26: timeout counter width, with 2^W_TIMEOUT > TIMEOUT.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `nivel`  in  12  measured level, 3 BCD digits (cm).
- `nivel_pronto`  in  1  one-cycle strobe; `nivel` is valid while high.
- `nv_crit`, `nv_alto`, `nv_baixo`  in  12 each  BCD thresholds.
- `manual`  in  1  manual mode request.
- `abrir_valv`  in  1  manual valve command.
- `limpa_falha`  in  1  one-cycle fault-clear pulse.
- `valvula`  out  1  fill valve open.
- `alarme`  out  1  alarm.
- `falha`  out  1  fill-timeout fault latched.
- `db_estado`  out  3  current state code.

## Operation
- **Zone classification** on each `nivel_pronto`, in priority order:
  - CRIT if `nivel >= nv_crit`
  - else ALTO if `nivel >= nv_alto`
  - else BAIXO if `nivel <= nv_baixo`
  - else MEIO.
- Comparisons are plain 12-bit unsigned, which is numerically correct for valid BCD. Non-BCD inputs are not checked.
- Misordered thresholds still classify deterministically by the priority above.
- **Zone counter:**
  - Counts consecutive strobed samples with identical zone. It restarts at 1 on a zone change and saturates at `N_CONFIRMA`.
  - A zone is "confirmed" on the strobe that brings the count to `N_CONFIRMA`.
  - The counter clears to 0 on every state change.
  - `last_zone` holds the zone of the most recent sample.
- **States and `db_estado` codes:** INICIAL=0, OCIOSO=1, ENCHENDO=2, CRITICO=3, FALHA=4, MANUAL=5.
- **Transitions**, evaluated each edge in this priority: FALHA handling > manual > zone confirmation > timeout.
  - INICIAL → OCIOSO on the first `nivel_pronto`.
  - Any state except FALHA → MANUAL when `manual`=1.
  - MANUAL → OCIOSO when `manual`=0.
  - OCIOSO → ENCHENDO on confirmed BAIXO; OCIOSO → CRITICO on confirmed CRIT.
  - ENCHENDO → CRITICO on confirmed CRIT; ENCHENDO → OCIOSO on confirmed ALTO.
  - ENCHENDO → FALHA when the timeout counter reaches `TIMEOUT-1`.
  - CRITICO → OCIOSO on confirmed MEIO or BAIXO.
  - FALHA → OCIOSO on `limpa_falha`=1. `manual` is ignored while in FALHA.
- **Timeout counter:** zeroed on entry to ENCHENDO, increments every cycle in ENCHENDO, and is held at 0 elsewhere.
- **Outputs** (registered, decoded from next state):
  - `valvula` = 1 in ENCHENDO.
  - In MANUAL, `valvula` = `abrir_valv` AND (`last_zone` ≠ CRIT). This is an unconfirmed, immediate safety cut.
  - `valvula` = 0 in all other states.
  - `alarme` = 1 in CRITICO and FALHA, and in MANUAL when `last_zone` = CRIT.
  - `falha` = 1 only in FALHA.

## Timing
- **Reset** (`reset`=0 at an edge):
  - State INICIAL, both counters 0, `last_zone` MEIO.
  - `valvula`=0, `alarme`=0, `falha`=0, `db_estado`=0.
- **Reset mid-operation** aborts immediately. The valve closes at that edge, and a fault is not retained.
- **Confirmation latency:** state and outputs update on the same edge that samples the N-th confirming strobe, i.e. visible 1 cycle after that strobe cycle.
- **Manual entry/exit:** 1 cycle after `manual` changes. In MANUAL, `valvula` follows `abrir_valv` with 1-cycle latency.
- **Safety cut:** a CRIT sample in MANUAL forces `valvula`=0 one cycle after the strobe.
- **Timeout:** FALHA is entered exactly `TIMEOUT` cycles after entering ENCHENDO, if no confirmation occurred first.
- **Simultaneous events:**
  - Confirmation on the same edge as the timeout: confirmation wins.
  - `manual` on the same edge as a confirmation: MANUAL wins.
- Threshold inputs are sampled combinationally on each strobe. Changing them mid-sequence affects only later samples; the counter is not reset.

## Test plan
- Reset with `reset`=0 for 2 cycles → all outputs 0, `db_estado`=0. First strobe with `nivel`=12'h018 → `db_estado`=1.
- Thresholds 12'h027/12'h024/12'h012, in OCIOSO, three strobes of `nivel`=12'h010 → `valvula`=1 and `db_estado`=2 one cycle after the 3rd strobe. Sequence 12'h010, 12'h015, 12'h010 → no transition.
- In ENCHENDO, three strobes of 12'h025 → OCIOSO, `valvula`=0. Three strobes of 12'h030 instead → CRITICO, `alarme`=1. Then three strobes of 12'h020 → OCIOSO, `alarme`=0.
- `TIMEOUT`=20, enter ENCHENDO, no further strobes → FALHA 20 cycles later with `falha`=1, `alarme`=1, `valvula`=0. `manual`=1 is ignored. `limpa_falha` pulse → OCIOSO.
- `manual`=1, `abrir_valv`=1 → `valvula`=1 two cycles later. One strobe of 12'h030 → `valvula`=0 and `alarme`=1 next cycle. `manual`=0 → OCIOSO.
- In ENCHENDO, assert `reset`=0 for one edge → `valvula`=0, state INICIAL on that edge.
